// File: rtl/seq_signed_divider.sv
// Iterative radix-2 restoring divider for two's-complement operands.
// One division per accepted start; result and flags are presented with a one-cycle done pulse.
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, next_state;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] abs_b;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r;
    logic             flag_dz, flag_ov;

    logic [WIDTH-1:0] abs_a_in, abs_b_in;
    logic             is_dz, is_ov;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    // Magnitudes are unsigned, so the most negative operand maps cleanly onto 2^(WIDTH-1).
    assign abs_a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign abs_b_in = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign is_dz    = (B == '0);
    assign is_ov    = (A == MIN_VAL) && (B == '1);

    assign p_sh     = {p[WIDTH-1:0], q[WIDTH-1]};
    assign trial    = {1'b0, p_sh} - {2'b00, abs_b};
    assign trial_ok = ~trial[WIDTH+1];

    assign busy = (state != IDLE);

    // NOTE: asynchronous reset belongs in the sensitivity list; state updates use <= so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (is_dz || is_ov) ? FIX : RUN;
            RUN:  if (count == CW'(1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p         <= '0;
            q         <= '0;
            abs_b     <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            flag_dz   <= 1'b0;
            flag_ov   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        abs_b   <= abs_b_in;
                        count   <= CW'(WIDTH);
                        flag_dz <= is_dz;
                        flag_ov <= is_ov;
                        // Special cases preload the final magnitudes so FIX handles them uniformly.
                        if (is_dz) begin
                            q      <= '1;
                            p      <= {1'b0, A};
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end else if (is_ov) begin
                            q      <= MIN_VAL;
                            p      <= '0;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end else begin
                            q      <= abs_a_in;
                            p      <= '0;
                            sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r <= A[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    p     <= trial_ok ? trial[WIDTH:0] : p_sh;
                    q     <= {q[WIDTH-2:0], trial_ok};
                    count <= count - 1'b1;
                end
                FIX: begin
                    quotient  <= sign_q ? (~q + 1'b1) : q;
                    remainder <= sign_r ? (~p[WIDTH-1:0] + 1'b1) : p[WIDTH-1:0];
                    div_zero  <= flag_dz;
                    overflow  <= flag_ov;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: vector table, random operands and
// hand-written sequences, with a scoreboard checked on every done pulse.
module tb_seq_signed_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done, div_zero, overflow;
    logic [W-1:0] quotient, remainder;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dz, ov;
        int           lat;
    } vec_t;

    vec_t         sb_q[$];
    vec_t         vecs[13];
    int           tot  = 0;
    int           errs = 0;
    logic [W-1:0] last_q = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tot++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, b, q, r, input logic dz, ov, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat;
        return v;
    endfunction

    // Reference model built on the simulator's signed / and %, which truncate toward zero.
    function automatic vec_t model(input logic [W-1:0] a, b);
        vec_t v;
        logic signed [W-1:0] sa, sb;
        sa = a; sb = b;
        v = mk(a, b, '0, '0, 1'b0, 1'b0, 33);
        if (b == '0) begin
            v.q = '1; v.r = a; v.dz = 1'b1; v.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.q = 32'h8000_0000; v.r = '0; v.ov = 1'b1; v.lat = 1;
        end else begin
            v.q = sa / sb;
            v.r = sa % sb;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                tot++; errs++;
                $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check($sformatf("quotient(%0d/%0d)", $signed(e.a), $signed(e.b)), quotient, e.q);
                check($sformatf("remainder(%0d/%0d)", $signed(e.a), $signed(e.b)), remainder, e.r);
                check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                check("overflow", {31'd0, overflow}, {31'd0, e.ov});
                last_q = e.q;
            end
        end
    end

    // Drives one start in the low half of the cycle; returns just after the accepting edge.
    task automatic issue(input vec_t v, input bit push);
        @(negedge clk);
        A = v.a; B = v.b; start = 1'b1;
        if (push) sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    // Counts edges until done, checking busy and that outputs hold mid-operation.
    task automatic wait_done(input int exp_lat, input string name);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (lat == 5) check({name, "_hold_q"}, quotient, last_q);
            if (lat >= 200) begin
                $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, lat);
                break;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic done_pulse_check(input string name);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t v;

        vecs[0]  = mk(32'd2000,       -32'sd40,      -32'sd50,      32'd0,        1'b0, 1'b0, 33);
        vecs[1]  = mk(-32'sd6307,     32'd70,        -32'sd90,      -32'sd7,      1'b0, 1'b0, 33);
        vecs[2]  = mk(32'd6307,       -32'sd70,      -32'sd90,      32'd7,        1'b0, 1'b0, 33);
        vecs[3]  = mk(32'd98765,      32'd0,         32'hFFFF_FFFF, 32'd98765,    1'b1, 1'b0, 1);
        vecs[4]  = mk(32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 1'b1, 1);
        vecs[5]  = mk(32'h8000_0000,  32'd1,         32'h8000_0000, 32'd0,        1'b0, 1'b0, 33);
        vecs[6]  = mk(-32'sd7,        32'd2,         -32'sd3,       -32'sd1,      1'b0, 1'b0, 33);
        vecs[7]  = mk(32'd7,          32'd7,         32'd1,         32'd0,        1'b0, 1'b0, 33);
        vecs[8]  = mk(32'h8000_0000,  32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1);
        vecs[9]  = mk(32'd0,          32'd5,         32'd0,         32'd0,        1'b0, 1'b0, 33);
        vecs[10] = mk(32'h7FFF_FFFF,  32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0, 1'b0, 33);
        vecs[11] = mk(32'h8000_0000,  32'h8000_0000, 32'd1,         32'd0,        1'b0, 1'b0, 33);
        vecs[12] = mk(32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);

        reset = 1'b0; start = 1'b0; A = '0; B = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i], 1'b1);
            wait_done(vecs[i].lat, $sformatf("vec%0d", i));
            done_pulse_check($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 100)) : W'($urandom);
            if (i == 3) rb = '0;
            v = model(ra, rb);
            issue(v, 1'b1);
            wait_done(v.lat, $sformatf("rand%0d", i));
        end

        // A start ten cycles into an operation is ignored; then a back-to-back start on done.
        issue(vecs[0], 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        A = 32'd1; B = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(23, "ignored_start");
        issue(mk(-32'sd998001, 32'd999, -32'sd999, 32'd0, 1'b0, 1'b0, 33), 1'b1);
        wait_done(33, "back_to_back");
        done_pulse_check("back_to_back");

        // Reset mid-operation clears everything at once and the aborted op never completes.
        issue(mk(-32'sd1000000, 32'd2000, -32'sd500, 32'd0, 1'b0, 1'b0, 33), 1'b0);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_flags", {30'd0, div_zero, overflow}, 32'd0);
        last_q = '0;
        @(negedge clk);
        reset = 1'b1;
        issue(mk(-32'sd1000000, 32'd2000, -32'sd500, 32'd0, 1'b0, 1'b0, 33), 1'b1);
        wait_done(33, "after_abort");
        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot, errs);
        $finish;
    end

endmodule
